// File: rtl/vector_dot_pkg.sv
// rtl/vector_dot_pkg.sv - shared state encoding and fixed-point shift/saturate helper
package vector_dot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CALC_WIDTH = 64;

    // Arithmetic shift (floor) followed by clamping to a signed range of the given width.
    function automatic logic signed [CALC_WIDTH-1:0] shift_sat(
        input logic signed [CALC_WIDTH-1:0] prod,
        input int                           frac,
        input int                           width
    );
        logic signed [CALC_WIDTH-1:0] shifted;
        logic signed [CALC_WIDTH-1:0] max_v;
        logic signed [CALC_WIDTH-1:0] min_v;
        shifted = prod >>> frac;
        max_v   = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v   = -max_v - 64'sd1;
        if (shifted > max_v) begin
            return max_v;
        end else if (shifted < min_v) begin
            return min_v;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/vector_dot_mult_cell.sv
// rtl/vector_dot_mult_cell.sv - one signed multiply, fraction shift and saturate lane
module vector_dot_mult_cell
    import vector_dot_pkg::*;
#(
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 10,
    parameter int FRACTION          = 2
) (
    input  logic [A_CELL_WIDTH-1:0]      a,
    input  logic [B_CELL_WIDTH-1:0]      b,
    output logic [RESULT_CELL_WIDTH-1:0] value,
    output logic                         overflow
);
    localparam int PROD_WIDTH = A_CELL_WIDTH + B_CELL_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [CALC_WIDTH-1:0] prod_ext;
    logic signed [CALC_WIDTH-1:0] sat;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(CALC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    assign sat      = shift_sat(prod_ext, FRACTION, RESULT_CELL_WIDTH);
    assign value    = sat[RESULT_CELL_WIDTH-1:0];
    // Clamping changed the value exactly when the shifted product was out of range.
    assign overflow = (sat != (prod_ext >>> FRACTION));

endmodule

// File: rtl/vector_dot.sv
// rtl/vector_dot.sv - element-wise fixed-point vector multiply processed TILING lanes per clock
module vector_dot
    import vector_dot_pkg::*;
#(
    parameter int VECTOR_LEN        = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 10,
    parameter int FRACTION          = 2,
    parameter int TILING            = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a,
    input  logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b,
    output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
    output logic                                    valid,
    output logic                                    error
);
    localparam int CHUNKS = (VECTOR_LEN + TILING - 1) / TILING;
    localparam int CW     = $clog2(CHUNKS + 1);
    localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

    state_t state;
    state_t next_state;

    logic [CW-1:0]                           chunk;
    logic [VECTOR_LEN*A_CELL_WIDTH-1:0]      a_reg;
    logic [VECTOR_LEN*B_CELL_WIDTH-1:0]      b_reg;
    logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result_reg;
    logic                                    error_reg;

    int                             base;
    logic [A_CELL_WIDTH-1:0]        a_sel    [TILING];
    logic [B_CELL_WIDTH-1:0]        b_sel    [TILING];
    logic [RESULT_CELL_WIDTH-1:0]   cell_val [TILING];
    logic [TILING-1:0]              cell_ovf;
    logic [TILING-1:0]              lane_on;

    // Lanes past the end of the vector in the final chunk stay idle.
    always_comb begin
        base = int'(chunk) * TILING;
        for (int t = 0; t < TILING; t++) begin
            lane_on[t] = (base + t < VECTOR_LEN);
            a_sel[t]   = '0;
            b_sel[t]   = '0;
            if (lane_on[t]) begin
                a_sel[t] = a_reg[(base + t)*A_CELL_WIDTH +: A_CELL_WIDTH];
                b_sel[t] = b_reg[(base + t)*B_CELL_WIDTH +: B_CELL_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < TILING; g++) begin : g_cell
        vector_dot_mult_cell #(
            .A_CELL_WIDTH     (A_CELL_WIDTH),
            .B_CELL_WIDTH     (B_CELL_WIDTH),
            .RESULT_CELL_WIDTH(RESULT_CELL_WIDTH),
            .FRACTION         (FRACTION)
        ) u_cell (
            .a       (a_sel[g]),
            .b       (b_sel[g]),
            .value   (cell_val[g]),
            .overflow(cell_ovf[g])
        );
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = BUSY;
            BUSY:    if (chunk == LAST_CHUNK) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            chunk      <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        chunk     <= '0;
                        error_reg <= 1'b0;
                    end
                end
                BUSY: begin
                    chunk     <= chunk + 1'b1;
                    error_reg <= error_reg | (|(cell_ovf & lane_on));
                    for (int t = 0; t < TILING; t++) begin
                        if (lane_on[t]) begin
                            result_reg[(base + t)*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] <= cell_val[t];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid  = (state == DONE);
    assign result = result_reg;
    assign error  = error_reg;

endmodule

// File: tb/tb_vector_dot.sv
// tb/tb_vector_dot.sv - directed self-checking bench for vector_dot at TILING 1, 2 and 5
module tb_vector_dot;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [39:0] a;
    logic [39:0] b;
    logic [49:0] result [3];
    logic        valid  [3];
    logic        error  [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vector_dot #(.TILING(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .result(result[0]), .valid(valid[0]), .error(error[0])
    );
    vector_dot #(.TILING(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .result(result[1]), .valid(valid[1]), .error(error[1])
    );
    vector_dot #(.TILING(5)) dut5 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .result(result[2]), .valid(valid[2]), .error(error[2])
    );

    function automatic logic [39:0] pk8(input int e0, input int e1, input int e2, input int e3, input int e4);
        return {8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [49:0] pk10(input int e0, input int e1, input int e2, input int e3, input int e4);
        return {10'(e4), 10'(e3), 10'(e2), 10'(e1), 10'(e0)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One start pulse; each DUT must pulse valid once, C edges after start, with the given data.
    task automatic do_op(input string tag, input logic [49:0] exp_res, input logic exp_err);
        int first [3];
        int pulses [3];
        logic [49:0] res_at [3];
        logic err_at [3];
        for (int d = 0; d < 3; d++) begin
            first[d] = -1; pulses[d] = 0; res_at[d] = '0; err_at[d] = 1'b0;
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (valid[d]) begin
                    pulses[d]++;
                    if (first[d] < 0) begin
                        first[d]  = n;
                        res_at[d] = result[d];
                        err_at[d] = error[d];
                    end
                end
            end
        end
        chk({tag, " lat t1"}, 64'(first[0]), 64'd5);
        chk({tag, " lat t2"}, 64'(first[1]), 64'd3);
        chk({tag, " lat t5"}, 64'(first[2]), 64'd1);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s pulses d%0d", tag, d), 64'(pulses[d]), 64'd1);
            chk($sformatf("%s result d%0d", tag, d), 64'(res_at[d]), 64'(exp_res));
            chk($sformatf("%s error d%0d", tag, d), 64'(err_at[d]), 64'(exp_err));
            chk($sformatf("%s hold d%0d", tag, d), 64'(result[d]), 64'(exp_res));
        end
    endtask

    initial begin
        int pulses;
        int prev;
        int consec;
        rst   = 1'b0;
        start = 1'b1;
        a     = pk8(-10, 20, 30, 31, 50);
        b     = pk8(1, 4, -3, -3, 4);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset result d%0d", d), 64'(result[d]), 64'd0);
            chk($sformatf("reset valid d%0d", d), 64'(valid[d]), 64'd0);
            chk($sformatf("reset error d%0d", d), 64'(error[d]), 64'd0);
        end
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);

        do_op("basic", pk10(-3, 20, -23, -24, 50), 1'b0);

        a = pk8(-10, 20, 127, 120, 50);
        b = pk8(50, 40, -128, -120, 10);
        do_op("overflow", pk10(-125, 200, -512, -512, 125), 1'b1);

        a = pk8(127, 20, 30, 31, 50);
        b = pk8(127, 4, -3, -3, 4);
        do_op("possat", pk10(511, 20, -23, -24, 50), 1'b1);

        a = pk8(-10, 20, 30, 31, 50);
        b = pk8(1, 4, -3, -3, 4);
        do_op("clean", pk10(-3, 20, -23, -24, 50), 1'b0);

        // Start held for 10 edges: accepted at edge 0 and again at edge 7 after DONE.
        pulses = 0; prev = 0; consec = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (valid[0]) begin
                pulses++;
                if (prev != 0) consec++;
            end
            prev = int'(valid[0]);
            if (n == 2) begin
                a = pk8(-10, 20, 127, 120, 50);
                b = pk8(50, 40, -128, -120, 10);
            end
            if (n == 5) begin
                chk("held valid1", 64'(valid[0]), 64'd1);
                chk("held result1", 64'(result[0]), 64'(pk10(-3, 20, -23, -24, 50)));
            end
            if (n == 12) begin
                chk("held valid2", 64'(valid[0]), 64'd1);
                chk("held result2", 64'(result[0]), 64'(pk10(-125, 200, -512, -512, 125)));
            end
            if (n == 9) start = 1'b0;
        end
        chk("held pulses", 64'(pulses), 64'd2);
        chk("held consec", 64'(consec), 64'd0);

        // Reset asserted at edge k+2 aborts the operation silently.
        a = pk8(-10, 20, 30, 31, 50);
        b = pk8(1, 4, -3, -3, 4);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        chk("abort result", 64'(result[0]), 64'd0);
        chk("abort valid", 64'(valid[0]), 64'd0);
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (valid[0]) pulses++;
        end
        chk("abort no pulse", 64'(pulses), 64'd0);
        chk("abort result hold", 64'(result[0]), 64'd0);

        do_op("fresh", pk10(-3, 20, -23, -24, 50), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vector_dot.md
VECTOR_DOT -- requirements
Module: vector_dot

Interface
REQ-001 SHALL have parameter VECTOR_LEN, default 5: number of elements per vector.
REQ-002 SHALL have parameter A_CELL_WIDTH, default 8: signed width of each a element.
REQ-003 SHALL have parameter B_CELL_WIDTH, default 8: signed width of each b element.
REQ-004 SHALL have parameter RESULT_CELL_WIDTH, default 10: signed width of each result element.
REQ-005 SHALL have parameter FRACTION, default 2: fractional bits removed from each product.
REQ-006 SHALL have parameter TILING, default 1: element multiplications per clock, 1..VECTOR_LEN.
REQ-007 SHALL use one clock and a synchronous, active-low reset.
REQ-008 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-009 SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-010 SHALL have port start, input, 1 bit: one-cycle request to begin an operation.
REQ-011 SHALL have port a, input, VECTOR_LEN*A_CELL_WIDTH bits: element i at bits [i*A_CELL_WIDTH +: A_CELL_WIDTH].
REQ-012 SHALL have port b, input, VECTOR_LEN*B_CELL_WIDTH bits: packed the same way as a.
REQ-013 SHALL have port result, output, VECTOR_LEN*RESULT_CELL_WIDTH bits: element-wise products, element i at [i*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH].
REQ-014 SHALL have port valid, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port error, output, 1 bit: overflow flag for the last operation.

Function
REQ-016 SHALL compute, per element i, result[i] = sat(floor(a[i]*b[i] / 2^FRACTION)); all values are two's-complement signed.
REQ-017 SHALL form the full-precision product (A_CELL_WIDTH+B_CELL_WIDTH bits), then arithmetic-shift it right by FRACTION, so results round toward minus infinity.
REQ-018 SHALL saturate each shifted product to the RESULT_CELL_WIDTH signed range: above max gives max (511 at default), below min gives min (-512 at default).
REQ-019 SHALL set error to 1 if any element of the operation saturated, and to 0 otherwise.
REQ-020 SHALL use a state machine with states IDLE, BUSY and DONE.
REQ-021 In IDLE, SHALL latch a and b on an edge where start=1, clear the chunk counter, and go to BUSY.
REQ-022 In BUSY, SHALL process elements [j*TILING, j*TILING+TILING-1] in chunk j on each edge, for C = ceil(VECTOR_LEN/TILING) edges; the last chunk covers only the remaining elements.
REQ-023 After the final chunk, SHALL go to DONE, where valid=1 for exactly one cycle, then return to IDLE.
REQ-024 Latency: with the start edge at k, valid SHALL be high during the cycle after edge k+C (defaults: 5 edges after start).
REQ-025 SHALL ignore start while in BUSY or DONE; inputs changing after the start edge SHALL NOT affect the operation.
REQ-026 SHALL hold result and error stable from DONE until the next accepted start; intermediate result values during BUSY are unspecified.
REQ-027 If start=1 in the IDLE cycle right after DONE, SHALL accept it normally.

Reset
REQ-028 While rst=0 at a rising edge: state IDLE, result all zeros, valid=0, error=0, chunk counter 0.
REQ-029 Reset during BUSY or DONE SHALL abort the operation, and no valid pulse SHALL be issued for it.
REQ-030 Reset SHALL take priority over start.

Structure
REQ-031 A shared package SHALL hold the state enumeration (IDLE, BUSY, DONE) and a signed saturate/shift function parameterized by widths.
REQ-032 The per-element multiply, shift and saturate SHALL be one sub-module, vector_dot_mult_cell, instantiated TILING times; it outputs the saturated value and an overflow bit.
REQ-033 The top level SHALL contain the FSM, the chunk counter, the operand registers, the result register and the error OR-reduction.

Verification (defaults; element lists are written index 0 first)
REQ-034 Basic: a=(-10,20,30,31,50), b=(1,4,-3,-3,4), one start pulse -> valid after 5 edges, result=(-3,20,-23,-24,50), error=0.
REQ-035 Overflow: a=(-10,20,127,120,50), b=(50,40,-128,-120,10) -> result=(-125,200,-512,-512,125), error=1.
REQ-036 Positive saturation: a[0]=127, b[0]=127 (product 16129, shifted 4032) -> result[0]=511, error=1; the next clean operation returns error=0.
REQ-037 Start held high for 10 cycles -> exactly one operation per IDLE entry; each valid pulse lasts one cycle; inputs changed mid-BUSY do not alter the result.
REQ-038 Reset mid-BUSY (rst=0 at edge k+2) -> result=0, no valid pulse; a fresh start afterwards completes correctly.
REQ-039 TILING=2 and TILING=5 with the REQ-034 data -> the same result, with valid after 3 and 1 edges respectively.
